// File: rtl/pipe_adder_pkg.sv
// Shared elaboration helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

    // Pipeline depth: one stage per CHUNK-bit slice of the operands.
    function automatic int stage_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal configurations: CHUNK in 1..WIDTH and an exact divisor of WIDTH.
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells.
module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// valid/ready on both sides, whole pipeline freezes on output back-pressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       rst,
    pipe_adder_if.slave io
);
    localparam int STAGES = stage_count(WIDTH, CHUNK);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $fatal(1, "pipe_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    // Stage registers. Operands are kept shifted down so the next stage
    // always consumes the low CHUNK bits; the partial sum is filled from the
    // top so slice 0 lands at bit 0 after the final stage.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              cm_q, cm_d;

    // Per-stage slice adder connections.
    logic [CHUNK-1:0]  ch_a  [STAGES];
    logic [CHUNK-1:0]  ch_b  [STAGES];
    logic [CHUNK-1:0]  ch_s  [STAGES];
    logic              ch_ci [STAGES];
    logic              ch_co [STAGES];
    logic              ch_cm [STAGES];

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic              adv;
    logic              accept;

    assign b_eff  = io.b ^ {WIDTH{io.sub}};
    assign c0     = io.sub ? 1'b1 : io.cin;
    assign adv    = !vld_q[STAGES-1] || io.out_ready;
    assign io.in_ready = adv && !rst;
    assign accept = io.in_valid && io.in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ch_a[k]  = io.a[CHUNK-1:0];
            assign ch_b[k]  = b_eff[CHUNK-1:0];
            assign ch_ci[k] = c0;
        end else begin : g_next
            assign ch_a[k]  = a_q[k-1][CHUNK-1:0];
            assign ch_b[k]  = b_q[k-1][CHUNK-1:0];
            assign ch_ci[k] = c_q[k-1];
        end

        rca_chunk #(.CHUNK(CHUNK)) u_rca (
            .a     (ch_a[k]),
            .b     (ch_b[k]),
            .ci    (ch_ci[k]),
            .s     (ch_s[k]),
            .co    (ch_co[k]),
            .c_msb (ch_cm[k])
        );
    end

    // Next-state: hold everything while stalled, otherwise shift every stage
    // forward one slot (bubbles included).
    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        cm_d  = cm_q;
        if (adv) begin
            vld_d[0] = accept;
            a_d[0]   = io.a >> CHUNK;
            b_d[0]   = b_eff >> CHUNK;
            s_d[0]   = WIDTH'(ch_s[0]) << (WIDTH - CHUNK);
            c_d[0]   = ch_co[0];
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1] >> CHUNK;
                b_d[k]   = b_q[k-1] >> CHUNK;
                s_d[k]   = (s_q[k-1] >> CHUNK) | (WIDTH'(ch_s[k]) << (WIDTH - CHUNK));
                c_d[k]   = ch_co[k];
            end
            cm_d = ch_cm[STAGES-1];
        end
    end

    // Stage registers; reset drops every in-flight beat and zeroes the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            cm_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            cm_q  <= cm_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign io.out_valid = vld_q[STAGES-1];
    assign io.sum       = s_q[STAGES-1];
    assign io.cout      = c_q[STAGES-1];
    assign io.ovf       = c_q[STAGES-1] ^ cm_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, CHUNK=4, latency 4).
module tb_pipe_adder;
    localparam int W   = 16;
    localparam int C   = 4;
    localparam int LAT = W / C;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    logic clk;
    logic rst;

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    exp_t pend;
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_err    = 0;
    bit   accepted = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         r;
        logic [W-1:0] be;
        logic [W:0]   full;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : cin);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
        r.due  = 0;
        return r;
    endfunction

    // One clock cycle: inputs are already driven; sample 1ns after the
    // falling edge, update the scoreboard, then advance to the next falling edge.
    task automatic step();
        bit   ev;
        bit   exp_rdy;
        exp_t e;
        #1;
        ev = (q.size() > 0) && (cyc == q[0].due);
        check_eq("out_valid", bus.out_valid, ev);
        exp_rdy = !rst && !(ev && !bus.out_ready);
        check_eq("in_ready", bus.in_ready, exp_rdy);
        if (ev) begin
            check_eq("sum", bus.sum, q[0].sum);
            check_eq("cout", bus.cout, q[0].cout);
            check_eq("ovf", bus.ovf, q[0].ovf);
        end
        accepted = bus.in_valid && exp_rdy;
        if (rst) begin
            q.delete();
        end else begin
            if (ev && bus.out_ready) begin
                void'(q.pop_front());
            end else if (ev) begin
                for (int i = 0; i < q.size(); i++) q[i].due = q[i].due + 1;
            end
            if (accepted) begin
                e     = pend;
                e.due = cyc + LAT;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    // Offer a beat until it is accepted (bounded).
    task automatic push_beat();
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!accepted && guard < 50);
        if (!accepted) check_eq("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        drive(a, b, cin, sub);
        pend = model(a, b, cin, sub);
        push_beat();
    endtask

    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] s, input logic co, input logic ov);
        drive(a, b, cin, sub);
        pend.sum  = s;
        pend.cout = co;
        pend.ovf  = ov;
        pend.due  = 0;
        push_beat();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        bit           have;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        pend          = model('0, '0, 1'b0, 1'b0);

        // Reset: outputs cleared, in_ready low while rst is high.
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_sum", bus.sum, 0);
            check_eq("rst_cout", bus.cout, 0);
            check_eq("rst_ovf", bus.ovf, 0);
        end
        rst = 1'b0;
        idle(2);

        // Directed vectors with hand-computed results.
        send_exp(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        idle(6);
        send_exp(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_exp(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_exp(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        idle(8);

        // Streaming: 8 back-to-back random beats.
        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(8);

        // Back-pressure: fill, then hold out_ready low 3 cycles with a beat offered.
        for (int i = 0; i < 4; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        ra = 16'($urandom);
        rb = 16'($urandom);
        drive(ra, rb, 1'b0, 1'b1);
        pend = model(ra, rb, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_no_accept", 32'(accepted), 32'd0);
        end
        bus.out_ready = 1'b1;
        push_beat();
        idle(8);

        // Reset with 3 beats in flight: none may ever appear.
        for (int i = 0; i < 3; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_mid_valid", bus.out_valid, 0);
        idle(8);
        send_exp(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        idle(6);

        // Random traffic with random back-pressure; producer holds unaccepted beats.
        have = 1'b0;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                have = 1'b1;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
            end
            if (have) begin
                drive(ra, rb, rc, rs);
                pend = model(ra, rb, rc, rs);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (accepted) have = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(12);
        check_eq("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
